dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-ported 32 x 32 data memory. It shares one memory port between requester 0 (processor load/store path) and requester 1 (loader/debug path) with round-robin fairness. It drives the memory's write-enable, write-data and address inputs, and returns registered read data with a one-cycle valid strobe. It sits between the requesters and the data memory; the memory writes on the rising edge and reads combinationally.

---
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester, memory-port and status signals shared between dmem_arbiter and its environment.
// The arbiter attaches through the slave modport; requesters and the memory use master.
interface dmem_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          gnt0;
   logic          gnt1;
   logic          rvalid0;
   logic          rvalid1;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;
   logic          mem_we;
   logic [DW-1:0] mem_wd;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_rd;
   logic          busy;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_we, mem_wd, mem_a, busy
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_we, mem_wd, mem_a, busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer for a single-ported data memory.
// Optional DMEM_CLEAR_EN: zero-fill sweep of every word after reset, with busy high meanwhile.
module dmem_arbiter #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);

`ifdef DMEM_CLEAR_EN
   typedef enum logic {ST_CLEAR, ST_RUN} state_t;
   localparam state_t ST_RESET = ST_CLEAR;
   logic [AW-1:0] sweep_q;
`else
   typedef enum logic {ST_RUN} state_t;
   localparam state_t ST_RESET = ST_RUN;
`endif

   state_t        state_q;
   state_t        state_d;
   logic          run;
   logic          busy_c;
   logic          last_q;
   logic          gnt0_c;
   logic          gnt1_c;
   logic          mem_we_c;
   logic [AW-1:0] mem_a_c;
   logic [DW-1:0] mem_wd_c;
   logic [AW-1:0] hold_a_q;
   logic [DW-1:0] hold_wd_q;
   logic          rvalid0_q;
   logic          rvalid1_q;
   logic [DW-1:0] rdata0_q;
   logic [DW-1:0] rdata1_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d  = state_q;
      run      = rst_n;
      busy_c   = 1'b0;
`ifdef DMEM_CLEAR_EN
      if (state_q == ST_CLEAR) begin
         run    = 1'b0;
         busy_c = 1'b1;
         if (sweep_q == '1) state_d = ST_RUN;
      end
`endif
      // Gating with rst_n drops an in-flight grant (and mem_we) the moment reset asserts.
      gnt0_c   = run & bus.req0 & (~bus.req1 | last_q);
      gnt1_c   = run & bus.req1 & (~bus.req0 | ~last_q);
      mem_we_c = 1'b0;
      mem_a_c  = hold_a_q;
      mem_wd_c = hold_wd_q;
      if (gnt0_c) begin
         mem_we_c = bus.we0;
         mem_a_c  = bus.addr0;
         mem_wd_c = bus.wdata0;
      end else if (gnt1_c) begin
         mem_we_c = bus.we1;
         mem_a_c  = bus.addr1;
         mem_wd_c = bus.wdata1;
      end
`ifdef DMEM_CLEAR_EN
      if (state_q == ST_CLEAR) begin
         mem_we_c = rst_n;
         mem_a_c  = sweep_q;
         mem_wd_c = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_RESET;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q    <= 1'b1;
         hold_a_q  <= '0;
         hold_wd_q <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
`ifdef DMEM_CLEAR_EN
         sweep_q   <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         hold_a_q  <= mem_a_c;
         hold_wd_q <= mem_wd_c;
         if (gnt0_c)      last_q <= 1'b0;
         else if (gnt1_c) last_q <= 1'b1;
         rvalid0_q <= gnt0_c & ~bus.we0;
         rvalid1_q <= gnt1_c & ~bus.we1;
         if (gnt0_c & ~bus.we0) rdata0_q <= bus.mem_rd;
         if (gnt1_c & ~bus.we1) rdata1_q <= bus.mem_rd;
`ifdef DMEM_CLEAR_EN
         if (state_q == ST_CLEAR) sweep_q <= sweep_q + AW'(1);
`endif
      end
   end

   assign bus.gnt0    = gnt0_c;
   assign bus.gnt1    = gnt1_c;
   assign bus.mem_we  = mem_we_c;
   assign bus.mem_a   = mem_a_c;
   assign bus.mem_wd  = mem_wd_c;
   assign bus.rvalid0 = rvalid0_q;
   assign bus.rvalid1 = rvalid1_q;
   assign bus.rdata0  = rdata0_q;
   assign bus.rdata1  = rdata1_q;
   assign bus.busy    = busy_c;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

`ifdef DMEM_CLEAR_EN
   localparam int CLR = 32;
`else
   localparam int CLR = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.DW(32), .AW(5)) bus ();
   dmem_arbiter #(.DW(32), .AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   // Environment memory: synchronous write, combinational read.
   logic [31:0] tb_mem [32];
   assign bus.mem_rd = tb_mem[bus.mem_a];
   always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_a] <= bus.mem_wd;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_val(input int a);
      return 32'h1000_0000 + a;
   endfunction

   function automatic logic [31:0] exp_init(input int a);
      return (CLR > 0) ? 32'h0 : init_val(a);
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [32];
   int          clr_left;
   bit          last;
   logic [4:0]  hold_a;
   logic [31:0] hold_wd;
   bit          rv0, rv1;
   logic [31:0] rd0, rd1;
   bit          g_prev0, g_prev1;

   function automatic void reset_model();
      clr_left = CLR;
      last     = 1'b1;
      hold_a   = '0;
      hold_wd  = '0;
      rv0 = 0; rv1 = 0;
      rd0 = '0; rd1 = '0;
      g_prev0 = 0; g_prev1 = 0;
   endfunction

   // Which port the rules say is granted right now (-1: none).
   function automatic int winner();
      if (!rst_n || clr_left > 0) return -1;
      if (bus.req0 && bus.req1) return last ? 0 : 1;
      if (bus.req0) return 0;
      if (bus.req1) return 1;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reset_model();
      end else if (clr_left > 0) begin
         ref_mem[CLR - clr_left] = '0;
         hold_a  = 5'(CLR - clr_left);
         hold_wd = '0;
         clr_left--;
         rv0 = 0; rv1 = 0;
         g_prev0 = 0; g_prev1 = 0;
      end else begin
         int w;
         bit we;
         logic [4:0] a;
         logic [31:0] d;
         w = winner();
         rv0 = 0; rv1 = 0;
         g_prev0 = (w == 0);
         g_prev1 = (w == 1);
         if (w >= 0) begin
            we = (w == 0) ? bus.we0 : bus.we1;
            a  = (w == 0) ? bus.addr0 : bus.addr1;
            d  = (w == 0) ? bus.wdata0 : bus.wdata1;
            last    = (w == 1);
            hold_a  = a;
            hold_wd = d;
            if (we) ref_mem[a] = d;
            else if (w == 0) begin rd0 = ref_mem[a]; rv0 = 1; end
            else             begin rd1 = ref_mem[a]; rv1 = 1; end
         end
      end
   end

   // Every-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      int w;
      logic        e_we;
      logic [4:0]  e_a;
      logic [31:0] e_wd;
      w = winner();
      if (!rst_n)            e_we = 1'b0;
      else if (clr_left > 0) e_we = 1'b1;
      else if (w == 0)       e_we = bus.we0;
      else if (w == 1)       e_we = bus.we1;
      else                   e_we = 1'b0;
      if (rst_n && clr_left > 0) begin e_a = 5'(CLR - clr_left); e_wd = '0; end
      else if (w == 0)           begin e_a = bus.addr0; e_wd = bus.wdata0; end
      else if (w == 1)           begin e_a = bus.addr1; e_wd = bus.wdata1; end
      else                       begin e_a = hold_a;    e_wd = hold_wd;    end
      check("gnt0", bus.gnt0, w == 0);
      check("gnt1", bus.gnt1, w == 1);
      check("mem_we", bus.mem_we, e_we);
      check("mem_a", bus.mem_a, e_a);
      check("mem_wd", bus.mem_wd, e_wd);
      check("busy", bus.busy, clr_left > 0);
      check("rvalid0", bus.rvalid0, rv0);
      check("rvalid1", bus.rvalid1, rv1);
      check("rdata0", bus.rdata0, rd0);
      check("rdata1", bus.rdata1, rd1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input int p, input bit r, input bit w, input int a, input logic [31:0] d);
      if (p == 0) begin
         bus.req0 = r; bus.we0 = w; bus.addr0 = 5'(a); bus.wdata0 = d;
      end else begin
         bus.req1 = r; bus.we1 = w; bus.addr1 = 5'(a); bus.wdata1 = d;
      end
   endtask

   task automatic access(input int p, input bit w, input int a, input logic [31:0] d,
                         output int waited);
      drive(p, 1, w, a, d);
      waited = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if ((p == 0 && bus.gnt0) || (p == 1 && bus.gnt1)) begin
            waited = i;
            break;
         end
      end
      check((p == 0) ? "access0_granted" : "access1_granted", waited >= 0, 1);
      @(posedge clk); #1;
      drive(p, 0, 0, 0, '0);
   endtask

   initial begin
      int wt, first, busy_n, tie_w;
      int order [4];

      rst_n = 1'b0;
      drive(0, 1, 0, 3, '0);       // req0 held from reset release
      drive(1, 0, 0, 0, '0);
      for (int i = 0; i < 32; i++) begin
         tb_mem[i]  = init_val(i);
         ref_mem[i] = init_val(i);
      end
      reset_model();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Boot: busy length and first-grant cycle.
      first = -1; busy_n = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (bus.gnt0) begin first = i; break; end
         if (bus.busy) busy_n++;
      end
      check("first_grant_cycle", first, CLR + 1);
      check("busy_cycles", busy_n, CLR);
      @(posedge clk); #1 drive(0, 0, 0, 0, '0);
      @(negedge clk);
      check("boot_rvalid0", bus.rvalid0, 1);
      check("boot_rdata0", bus.rdata0, exp_init(3));
      @(posedge clk); #1;

      // Uncontended write then read of the same word.
      access(0, 1, 5, 32'hDEADBEEF, wt);
      check("unc_wr_latency", wt, 0);
      access(0, 0, 5, '0, wt);
      check("unc_rd_latency", wt, 0);
      @(negedge clk);
      check("unc_rvalid0", bus.rvalid0, 1);
      check("unc_rdata0", bus.rdata0, 32'hDEADBEEF);
      check("unc_rvalid1", bus.rvalid1, 0);
      @(posedge clk); #1;

      // Contention: port 1 granted last, so port 0 leads.
      access(0, 1, 1, 32'h1111_1111, wt);
      access(1, 1, 2, 32'h2222_2222, wt);
      drive(0, 1, 0, 1, '0);
      drive(1, 1, 0, 2, '0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         order[k] = bus.gnt0 ? 0 : (bus.gnt1 ? 1 : -1);
         @(posedge clk); #1;
      end
      drive(0, 0, 0, 0, '0);
      drive(1, 0, 0, 0, '0);
      for (int k = 0; k < 4; k++) check("contention_order", order[k], k % 2);
      @(negedge clk);
      check("cont_rvalid1", bus.rvalid1, 1);
      check("cont_rdata1", bus.rdata1, 32'h2222_2222);
      check("cont_rdata0", bus.rdata0, 32'h1111_1111);
      @(posedge clk); #1;

      // Abort: port 1 loses a tie to streaming port 0, then withdraws.
      access(1, 1, 20, 32'h2020_2020, wt);
      drive(0, 1, 0, 4, '0);
      drive(1, 1, 1, 7, 32'hBAD0BAD0);
      @(negedge clk);
      check("abort_gnt0", bus.gnt0, 1);
      check("abort_gnt1", bus.gnt1, 0);
      check("abort_we", bus.mem_we, 0);
      @(posedge clk); #1;
      drive(1, 0, 0, 0, '0);
      drive(0, 1, 0, 6, '0);
      @(negedge clk);
      check("abort_we2", bus.mem_we, 0);
      @(posedge clk); #1 drive(0, 0, 0, 0, '0);
      access(1, 0, 7, '0, wt);
      @(negedge clk);
      check("abort_readback", bus.rdata1, exp_init(7));
      @(posedge clk); #1;

      // Reset asserted during a granted write, before its edge.
      drive(0, 1, 1, 9, 32'hCAFEF00D);
      @(negedge clk);
      check("rst_pre_gnt0", bus.gnt0, 1);
      check("rst_pre_we", bus.mem_we, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_we", bus.mem_we, 0);
      check("rst_gnt0", bus.gnt0, 0);
      check("rst_rdata0", bus.rdata0, 0);
      check("rst_rdata1", bus.rdata1, 0);
      check("rst_mem_a", bus.mem_a, 0);
      check("rst_mem_wd", bus.mem_wd, 0);
      check("rst_busy", bus.busy, CLR > 0);
      @(posedge clk); #1 drive(0, 0, 0, 0, '0);
      @(posedge clk); #1 rst_n = 1'b1;

      // First tie after reset goes to port 0; also reads back the aborted write target.
      drive(0, 1, 0, 9, '0);
      drive(1, 1, 0, 10, '0);
      tie_w = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.gnt0 || bus.gnt1) begin tie_w = bus.gnt0 ? 0 : 1; break; end
      end
      check("first_tie_winner", tie_w, 0);
      @(posedge clk); #1 drive(0, 0, 0, 0, '0);
      @(negedge clk);
      check("rst_tie_gnt1", bus.gnt1, 1);
      check("rst_readback", bus.rdata0, exp_init(9));
      @(posedge clk); #1 drive(1, 0, 0, 0, '0);

      // Randomized traffic obeying the requester protocol.
      for (int c = 0; c < 3000; c++) begin
         if (bus.req0 && !g_prev0) begin
            if ($urandom_range(0, 15) == 0) drive(0, 0, 0, 0, '0);
         end else if ($urandom_range(0, 9) < 6) begin
            drive(0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
         end else begin
            drive(0, 0, 0, 0, '0);
         end
         if (bus.req1 && !g_prev1) begin
            if ($urandom_range(0, 15) == 0) drive(1, 0, 0, 0, '0);
         end else if ($urandom_range(0, 9) < 6) begin
            drive(1, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
         end else begin
            drive(1, 0, 0, 0, '0);
         end
         @(posedge clk); #1;
      end
      drive(0, 0, 0, 0, '0);
      drive(1, 0, 0, 0, '0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
